// File: rtl/seg_serial_tx_if.sv
// ----------------------------------------------------------------------------
// Module   : seg_serial_tx_if
// Purpose  : Request/status and board-side serial bundle for seg_serial_tx.
//            The master side drives start/hexs and observes everything else.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface seg_serial_tx_if;
    logic        start;
    logic [31:0] hexs;
    logic        busy;
    logic        done;
    logic        seg_clk;
    logic        seg_sout;
    logic        seg_pen;
    logic        seg_clrn;

    modport master (
        output start, hexs,
        input  busy, done, seg_clk, seg_sout, seg_pen, seg_clrn
    );

    modport slave (
        input  start, hexs,
        output busy, done, seg_clk, seg_sout, seg_pen, seg_clrn
    );
endinterface

`default_nettype wire

// File: rtl/seg_serial_tx.sv
// ----------------------------------------------------------------------------
// Module   : seg_serial_tx
// Purpose  : Serialises a 32-bit graphic-mode segment word into a board
//            shift-register chain (seg_clk/seg_sout), then strobes seg_pen
//            to latch it and pulses done.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module seg_serial_tx #(
    parameter int DIV = 2
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    seg_serial_tx_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] C_DIV_M1 = 8'(DIV - 1);

    state_t      r_state;
    logic [31:0] r_shift;
    logic [4:0]  r_bit;
    logic [7:0]  r_phase;
    logic        r_busy;
    logic        r_done;
    logic        r_clk;
    logic        r_sout;
    logic        r_pen;
    logic        r_clrn;
    logic [31:0] w_frame;

    // Board wiring order: byte k of the frame gathers the segment bits of digit k.
    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign w_frame[31-8*k -: 8] = {bus.hexs[24+2*k], bus.hexs[12+k],
                                       bus.hexs[5+2*k],  bus.hexs[17+2*k],
                                       bus.hexs[25+2*k], bus.hexs[16+2*k],
                                       bus.hexs[4+2*k],  bus.hexs[k]};
    end

    // Frame sequencer: seg_clk is its own half-period flag, phase counts DIV cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_phase <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_clk   <= 1'b0;
            r_sout  <= 1'b0;
            r_pen   <= 1'b0;
            r_clrn  <= 1'b0;
        end else begin
            r_clrn <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_sout <= 1'b0;
                    r_clk  <= 1'b0;
                    r_pen  <= 1'b0;
                    r_done <= 1'b0;
                    // r_clrn gates acceptance so the chain leaves clear first.
                    if (bus.start && r_clrn) begin
                        r_state <= S_SHIFT;
                        r_busy  <= 1'b1;
                        r_sout  <= w_frame[31];
                        r_shift <= {w_frame[30:0], 1'b0};
                        r_bit   <= '0;
                        r_phase <= '0;
                    end
                end
                S_SHIFT: begin
                    if (r_phase == C_DIV_M1) begin
                        r_phase <= '0;
                        if (!r_clk) begin
                            r_clk <= 1'b1;
                        end else begin
                            r_clk <= 1'b0;
                            if (r_bit == 5'd31) begin
                                r_state <= S_LATCH;
                                r_pen   <= 1'b1;
                                r_sout  <= 1'b0;
                                r_bit   <= '0;
                            end else begin
                                r_bit   <= r_bit + 5'd1;
                                r_sout  <= r_shift[31];
                                r_shift <= {r_shift[30:0], 1'b0};
                            end
                        end
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                S_LATCH: begin
                    if (r_phase == C_DIV_M1) begin
                        r_phase <= '0;
                        r_state <= S_DONE;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.seg_clk  = r_clk;
    assign bus.seg_sout = r_sout;
    assign bus.seg_pen  = r_pen;
    assign bus.seg_clrn = r_clrn;

endmodule

`default_nettype wire
